// File: rtl/serial_alu_multiword.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_alu_multiword: chunk-serial multi-word ALU, LSB chunk first.         |
// | Optional feature macro: SERIAL_ALU_STALL_EN (advance input stalls a RUN).   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module serial_alu_multiword #(
    parameter int NSHIFT    = 2,
    parameter int WORD_BITS = 8,
    parameter int MAX_WORDS = 4,
    parameter int LEN_BITS  = $clog2(MAX_WORDS),
    parameter int CNT_BITS  = $clog2(MAX_WORDS*WORD_BITS/NSHIFT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [LEN_BITS-1:0] num_words_m1,
    input  logic                update_flags,
    input  logic                advance,
    input  logic [NSHIFT-1:0]   data_in1,
    input  logic [NSHIFT-1:0]   data_in2,
    output logic [NSHIFT-1:0]   data_out,
    output logic                active,
    output logic                busy,
    output logic                done,
    output logic                flag_c,
    output logic                flag_v,
    output logic                flag_s,
    output logic                flag_z,
    output logic [CNT_BITS-1:0] counter
);

    localparam int C_CHUNKS_PER_WORD = WORD_BITS / NSHIFT;
    localparam logic [2:0] C_OP_ADD = 3'd0;
    localparam logic [2:0] C_OP_SUB = 3'd1;
    localparam logic [2:0] C_OP_ADC = 3'd2;
    localparam logic [2:0] C_OP_SBC = 3'd3;
    localparam logic [2:0] C_OP_AND = 3'd4;
    localparam logic [2:0] C_OP_OR  = 3'd5;
    localparam logic [2:0] C_OP_XOR = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_BITS-1:0]   r_counter;
    logic                  r_carry;
    logic                  r_zero;
    logic [2:0]            r_op;
    logic [LEN_BITS-1:0]   r_len;
    logic                  r_upd;

    logic                  w_advance;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_first;
    logic                  w_cin;
    logic                  w_arith;
    logic                  w_sub;
    logic                  w_ovf;
    logic                  w_zero_run;
    logic [NSHIFT-1:0]     w_arg2;
    logic [NSHIFT-1:0]     w_result;
    logic [NSHIFT:0]       w_sum;
    logic [31:0]           w_last_idx;

`ifdef SERIAL_ALU_STALL_EN
    assign w_advance = advance;
`else
    logic w_unused_advance;
    assign w_unused_advance = advance;
    assign w_advance        = 1'b1;
`endif

    assign w_last_idx = (32'(r_len) + 32'd1) * 32'(C_CHUNKS_PER_WORD) - 32'd1;
    assign w_last     = (w_last_idx == 32'(r_counter));
    assign counter    = r_counter;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        active       = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                active = w_advance;
                done   = w_advance && w_last;
                // A completing chunk may chain straight into the next operation.
                if (done) begin
                    if (start) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_first = (r_counter == '0);
    assign w_arith = ~r_op[2];
    assign w_sub   = (r_op == C_OP_SUB) || (r_op == C_OP_SBC);
    assign w_arg2  = w_sub ? ~data_in2 : data_in2;

    always_comb begin
        w_cin = r_carry;
        if (w_first) begin
            case (r_op)
                C_OP_ADD: w_cin = 1'b0;
                C_OP_SUB: w_cin = 1'b1;
                C_OP_ADC: w_cin = flag_c;
                C_OP_SBC: w_cin = flag_c;
                default:  w_cin = 1'b0;
            endcase
        end
    end

    assign w_sum = {1'b0, data_in1} + {1'b0, w_arg2} + {{NSHIFT{1'b0}}, w_cin};
    assign w_ovf = (data_in1[NSHIFT-1] == w_arg2[NSHIFT-1]) &&
                   (w_sum[NSHIFT-1] != data_in1[NSHIFT-1]);

    always_comb begin
        w_result = w_sum[NSHIFT-1:0];
        case (r_op)
            C_OP_AND: w_result = data_in1 & data_in2;
            C_OP_OR:  w_result = data_in1 | data_in2;
            C_OP_XOR: w_result = data_in1 ^ data_in2;
            3'd7:     w_result = data_in2;
            default:  w_result = w_sum[NSHIFT-1:0];
        endcase
    end

    assign w_zero_run = (w_first ? 1'b1 : r_zero) & (w_result == '0);
    assign data_out   = (r_state == S_RUN) ? w_result : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_op      <= 3'd0;
            r_len     <= '0;
            r_upd     <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_s    <= 1'b0;
            flag_z    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op;
                r_len <= num_words_m1;
                r_upd <= update_flags;
            end
            if (active) begin
                r_counter <= done ? '0 : r_counter + 1'b1;
                r_carry   <= w_sum[NSHIFT];
                r_zero    <= w_zero_run;
                // Flags are committed only on the final chunk so they never tear.
                if (done && r_upd) begin
                    flag_c <= w_arith & w_sum[NSHIFT];
                    flag_v <= w_arith & w_ovf;
                    flag_s <= w_result[NSHIFT-1];
                    flag_z <= w_zero_run;
                end
            end
        end
    end

endmodule
`default_nettype wire
